alu_req_arbiter: RTL and testbench

- Shares the single 32-bit combinational ALU (sel 0=add, 1=sub, 2=and, 3=or) among NUM_REQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- The block drives the ALU operands and sel, registers the result, and returns it with the requester id on a one-entry response port with backpressure.
- Sits in core between the requesting units and the ALU instance.

---
 rtl/alu_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//   Shares one 32-bit combinational ALU (sel 0=add, 1=sub, 2=and, 3=or) among
//   NUM_REQ requesters. Round-robin grant, valid/ready on the request side,
//   and a one-entry registered response port with backpressure.
//
// Ports:
//   clk         system clock, all state updates on posedge
//   reset       synchronous, active-low reset
//   req_valid   per-requester request valid            [NUM_REQ]
//   req_ready   per-requester accept, one-hot or zero  [NUM_REQ]
//   req_op1     packed op1, requester i at [32*i +: 32]
//   req_op2     packed op2, same packing
//   req_sel     packed ALU sel, requester i at [2*i +: 2]
//   alu_op1/alu_op2/alu_sel  operands and op select to the shared ALU
//   alu_res     result from the shared ALU (same cycle)
//   resp_valid  response register holds a result
//   resp_ready  consumer accepts the response
//   resp_data   registered ALU result
//   resp_id     index of the requester that produced resp_data
//
// Optional feature (macro ALU_REQ_ARBITER_STATS_EN):
//   grant_count  number of grant edges since reset (wraps)
//   stall_count  edges with a pending request but no grant (wraps)
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_op1,
  input  logic [NUM_REQ*32-1:0] req_op2,
  input  logic [NUM_REQ*2-1:0] req_sel,
  output logic [31:0]          alu_op1,
  output logic [31:0]          alu_op2,
  output logic [1:0]           alu_sel,
  input  logic [31:0]          alu_res,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [ID_W-1:0]      resp_id
`ifdef ALU_REQ_ARBITER_STATS_EN
  ,
  output logic [31:0]          grant_count,
  output logic [31:0]          stall_count
`endif
);

  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q,  resp_data_d;
  logic [ID_W-1:0]   resp_id_q,    resp_id_d;
  logic [ID_W-1:0]   rr_ptr_q,     rr_ptr_d;

  logic              slot_free;
  logic              found;
  logic              grant;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W:0]     cand;

  logic [31:0]       op1_arr [NUM_REQ];
  logic [31:0]       op2_arr [NUM_REQ];
  logic [1:0]        sel_arr [NUM_REQ];

  // Unpack the flat request buses so the ALU mux can index by requester.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op1_arr[gi]   = req_op1[32*gi +: 32];
      assign op2_arr[gi]   = req_op2[32*gi +: 32];
      assign sel_arr[gi]   = req_sel[2*gi +: 2];
      assign req_ready[gi] = grant && (gnt_idx == ID_W'(gi));
    end
  endgenerate

  // The slot can take a new result if it is empty or draining this cycle.
  assign slot_free = !resp_valid_q || resp_ready;

  // Round-robin search: candidates rr_ptr, rr_ptr+1, ... wrapping modulo
  // NUM_REQ (which need not be a power of two, hence the explicit wrap).
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  assign grant = found && slot_free && reset;

  // Idle ALU inputs are forced to zero so nothing undefined reaches the ALU.
  assign alu_op1 = grant ? op1_arr[gnt_idx] : 32'd0;
  assign alu_op2 = grant ? op2_arr[gnt_idx] : 32'd0;
  assign alu_sel = grant ? sel_arr[gnt_idx] : 2'd0;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant) begin
      // Covers the simultaneous drain-and-refill case: valid stays high.
      resp_valid_d = 1'b1;
      resp_data_d  = alu_res;
      resp_id_d    = gnt_idx;
      rr_ptr_d     = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      rr_ptr_q     <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

`ifdef ALU_REQ_ARBITER_STATS_EN
  logic [31:0] grant_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant) begin
        grant_cnt_q <= grant_cnt_q + 32'd1;
      end
      if (|req_valid && !grant) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign grant_count = grant_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed steps followed by a random phase, all
// compared against a transaction-level model of the arbiter kept here.
module tb_alu_req_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_op1;
  logic [N*32-1:0] req_op2;
  logic [N*2-1:0] req_sel;
  logic [31:0]    alu_op1, alu_op2, alu_res;
  logic [1:0]     alu_sel;
  logic           resp_valid, resp_ready;
  logic [31:0]    resp_data;
  logic [1:0]     resp_id;
`ifdef ALU_REQ_ARBITER_STATS_EN
  logic [31:0]    grant_count, stall_count;
`endif

  alu_req_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sel(req_sel),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel), .alu_res(alu_res),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
`ifdef ALU_REQ_ARBITER_STATS_EN
    , .grant_count(grant_count), .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] s);
    case (s)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // The bench plays the role of the shared ALU.
  assign alu_res = alu_fn(alu_op1, alu_op2, alu_sel);

  logic [31:0] f_op1 [N];
  logic [31:0] f_op2 [N];
  logic [1:0]  f_sel [N];

  always_comb begin
    req_op1 = '0;
    req_op2 = '0;
    req_sel = '0;
    for (int i = 0; i < N; i++) begin
      req_op1[32*i +: 32] = f_op1[i];
      req_op2[32*i +: 32] = f_op2[i];
      req_sel[2*i +: 2]   = f_sel[i];
    end
  end

  int checks = 0;
  int errors = 0;

  // Model state: the response slot contents, the next-priority requester and
  // the stats totals.
  int          m_ptr = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_data = '0;
  int          m_id = 0;
  int          m_gc = 0;
  int          m_sc = 0;
  int          last_g = -1;
  logic [N-1:0] obs_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] s);
    f_op1[i] = a;
    f_op2[i] = b;
    f_sel[i] = s;
  endtask

  // One clock: drive inputs after the falling edge, check the combinational
  // grant and ALU drive, then check the registered response after the edge.
  task automatic step(input bit rst_n, input logic [N-1:0] v, input bit rr);
    int g;
    int c;
    logic [N-1:0] exp_ready;
    logic [31:0] e1, e2;
    logic [1:0]  es;
    @(negedge clk);
    reset = rst_n;
    req_valid = v;
    resp_ready = rr;
    #1;
    g = -1;
    if (rst_n && (!m_valid || rr)) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_ready = '0;
    e1 = '0; e2 = '0; es = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      e1 = f_op1[g]; e2 = f_op2[g]; es = f_sel[g];
    end
    obs_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("alu_op1", alu_op1, e1);
    chk("alu_op2", alu_op2, e2);
    chk("alu_sel", 32'(alu_sel), 32'(es));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_gc = 0; m_sc = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_data = alu_fn(f_op1[g], f_op2[g], f_sel[g]);
      m_id = g;
      m_ptr = (g + 1) % N;
      m_gc++;
    end else begin
      if (m_valid && rr) m_valid = 1'b0;
      if (v != '0) m_sc++;
    end
    last_g = g;
    chk("resp_valid", 32'(resp_valid), 32'(m_valid));
    chk("resp_data", resp_data, m_data);
    chk("resp_id", 32'(resp_id), 32'(m_id));
`ifdef ALU_REQ_ARBITER_STATS_EN
    chk("grant_count", grant_count, 32'(m_gc));
    chk("stall_count", stall_count, 32'(m_sc));
`endif
    $display("t=%0t rst_n=%0b valid=%b rr=%0b grant=%0d resp_v=%0b data=%h id=%0d",
             $time, rst_n, v, rr, g, resp_valid, resp_data, resp_id);
  endtask

  logic [31:0] hold_data;
  logic [1:0]  hold_id;
  logic [N-1:0] pend;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'd0, 32'd0, 2'd0);

    // Reset held with every requester asking.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 1'b1);
      chk("rst_ready", 32'(obs_ready), 32'd0);
      chk("rst_valid", 32'(resp_valid), 32'd0);
    end
    chk("rst_data", resp_data, 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);

    // Single request: 5 - 7 wraps to 0xFFFFFFFE.
    set_req(1, 32'd5, 32'd7, 2'd1);
    step(1'b1, 4'b0010, 1'b1);
    chk("single_ready", 32'(obs_ready), 32'h2);
    chk("single_data", resp_data, 32'hFFFF_FFFE);
    chk("single_id", 32'(resp_id), 32'd1);

    // Move the pointer back to 0, then all four valid continuously.
    set_req(3, 32'd1, 32'd1, 2'd0);
    step(1'b1, 4'b1000, 1'b1);
    for (int i = 0; i < N; i++) set_req(i, 32'(i), 32'd10, 2'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b1111, 1'b1);
      chk("rr_order", 32'(last_g), 32'(exp_order[k]));
      chk("rr_sum", resp_data, 32'(10 + exp_order[k]));
    end

    // Backpressure: response from req1, then four stalled cycles.
    set_req(1, 32'd100, 32'd1, 2'd0);
    step(1'b1, 4'b0010, 1'b1);
    hold_data = resp_data;
    hold_id = resp_id;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'b1100, 1'b0);
      chk("bp_ready", 32'(obs_ready), 32'd0);
      chk("bp_data", resp_data, hold_data);
      chk("bp_id", 32'(resp_id), 32'(hold_id));
    end
    step(1'b1, 4'b1100, 1'b1);
    chk("bp_resume", 32'(last_g), 32'd2);
    step(1'b1, 4'b1000, 1'b1);
    chk("bp_next", 32'(last_g), 32'd3);
    step(1'b1, 4'b0000, 1'b1);

    // Wrap-around add and the logic ops.
    set_req(0, 32'hFFFF_FFFF, 32'd1, 2'd0);
    step(1'b1, 4'b0001, 1'b1);
    chk("wrap_add", resp_data, 32'd0);
    set_req(0, 32'h0000_F0F0, 32'h0000_FF00, 2'd2);
    step(1'b1, 4'b0001, 1'b1);
    chk("op_and", resp_data, 32'h0000_F000);
    set_req(0, 32'h0000_F0F0, 32'h0000_FF00, 2'd3);
    step(1'b1, 4'b0001, 1'b1);
    chk("op_or", resp_data, 32'h0000_FFF0);

    // Reset while a response is held; pointer must return to 0.
    step(1'b1, 4'b0100, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    step(1'b1, 4'b1010, 1'b1);
    chk("midrst_first", 32'(last_g), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b1, 4'b1111, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0001, 1'b0);
`ifdef ALU_REQ_ARBITER_STATS_EN
    chk("stats_grants", grant_count, 32'd5);
    chk("stats_stalls", stall_count, 32'd4);
`endif
    step(1'b1, 4'b0000, 1'b1);

    // Random traffic: requests held until granted, random backpressure and
    // occasional reset.
    pend = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
        end
      end
      step(($urandom_range(0, 49) != 0), pend, ($urandom_range(0, 3) != 0));
      if (last_g >= 0) pend[last_g] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
